// File: rtl/change_dispenser.sv
// Greedy coin payout engine: drives one hopper pulse per coin, largest usable
// denomination first, and raises a sticky fault when the remainder cannot be paid.
module change_dispenser #(
  parameter int COIN_A    = 50,
  parameter int COIN_B    = 10,
  parameter int COIN_C    = 5,
  parameter int COIN_D    = 1,
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  state,
  input  logic [11:0] small_change,
  input  logic [3:0]  hopper_empty,
  output logic [1:0]  coin_sel,
  output logic        coin_pulse,
  output logic [11:0] remaining,
  output logic        busy,
  output logic        done,
  output logic        fault
);

  localparam logic [11:0] VAL_A      = 12'(COIN_A);
  localparam logic [11:0] VAL_B      = 12'(COIN_B);
  localparam logic [11:0] VAL_C      = 12'(COIN_C);
  localparam logic [11:0] VAL_D      = 12'(COIN_D);
  localparam logic [15:0] PULSE_LAST = 16'(PULSE_LEN - 1);
  localparam logic [15:0] GAP_LAST   = 16'(GAP_LEN - 1);

  typedef enum logic [2:0] {IDLE, SELECT, PULSE, GAP, FINISH} fsm_t;

  fsm_t        fsm;
  logic [15:0] cnt;
  logic        pick_ok;
  logic [1:0]  pick_sel;
  logic [11:0] coin_val;

  // First denomination, largest to smallest, that fits and whose hopper is stocked
  always_comb begin
    pick_ok  = 1'b0;
    pick_sel = 2'd0;
    if (!hopper_empty[3] && VAL_A <= remaining) begin
      pick_ok  = 1'b1;
      pick_sel = 2'd3;
    end else if (!hopper_empty[2] && VAL_B <= remaining) begin
      pick_ok  = 1'b1;
      pick_sel = 2'd2;
    end else if (!hopper_empty[1] && VAL_C <= remaining) begin
      pick_ok  = 1'b1;
      pick_sel = 2'd1;
    end else if (!hopper_empty[0] && VAL_D <= remaining) begin
      pick_ok  = 1'b1;
      pick_sel = 2'd0;
    end
  end

  always_comb begin
    coin_val = VAL_D;
    case (coin_sel)
      2'd3:    coin_val = VAL_A;
      2'd2:    coin_val = VAL_B;
      2'd1:    coin_val = VAL_C;
      default: coin_val = VAL_D;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fsm        <= IDLE;
      cnt        <= '0;
      coin_sel   <= 2'd0;
      coin_pulse <= 1'b0;
      remaining  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fault      <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          // Only "change due" and "exact" results produce a payout cycle
          if (start && !state[1]) begin
            remaining <= state[0] ? 12'd0 : small_change;
            fault     <= 1'b0;
            busy      <= 1'b1;
            fsm       <= SELECT;
          end
        end
        SELECT: begin
          if (remaining == 12'd0) begin
            done <= 1'b1;
            fsm  <= FINISH;
          end else if (pick_ok) begin
            coin_sel   <= pick_sel;
            coin_pulse <= 1'b1;
            cnt        <= '0;
            fsm        <= PULSE;
          end else begin
            fault <= 1'b1;
            done  <= 1'b1;
            fsm   <= FINISH;
          end
        end
        PULSE: begin
          if (cnt == PULSE_LAST) begin
            remaining  <= remaining - coin_val;
            coin_pulse <= 1'b0;
            cnt        <= '0;
            fsm        <= GAP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt <= '0;
            fsm <= SELECT;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        FINISH: begin
          done <= 1'b0;
          busy <= 1'b0;
          fsm  <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule
